// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid-buffer state encoding and bubble constant.
package pipe_pkg;

  // Encoding doubles as the occupancy count (entries held).
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] PIPE_BUBBLE_PC = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle of one elastic stage: upstream channel, downstream channel and status.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, stall_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones until reset or clr.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: main register plus one skid entry so in_ready comes straight from a flop.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input logic              clk,
  input logic              rst_n,
  pipe_skid_stage_if.slave bus
);

  pipe_state_e       state_reg;
  pipe_state_e       state_next;
  logic [DATA_W-1:0] main_reg;
  logic [DATA_W-1:0] skid_reg;
  logic              out_valid_reg;
  logic              in_ready_reg;
  logic              in_xfer;
  logic              out_xfer;
  logic              stall_inc;

  assign in_xfer  = bus.in_valid & in_ready_reg;
  assign out_xfer = out_valid_reg & bus.out_ready;

  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = PS_EMPTY;
    end else begin
      case (state_reg)
        PS_EMPTY: if (in_xfer) state_next = PS_BUSY;
        PS_BUSY: begin
          if (in_xfer && !out_xfer)      state_next = PS_FULL;
          else if (!in_xfer && out_xfer) state_next = PS_EMPTY;
        end
        PS_FULL:  if (out_xfer) state_next = PS_BUSY;
        default:  state_next = PS_EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so neither depends combinationally on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= PS_EMPTY;
      main_reg      <= RESET_VAL;
      skid_reg      <= RESET_VAL;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_next != PS_EMPTY);
      in_ready_reg  <= (state_next != PS_FULL);
      if (bus.flush) begin
        main_reg <= FLUSH_VAL;
        skid_reg <= FLUSH_VAL;
      end else begin
        case (state_reg)
          PS_EMPTY: if (in_xfer) main_reg <= bus.in_data;
          PS_BUSY: begin
            if (in_xfer && out_xfer) main_reg <= bus.in_data;
            else if (in_xfer)        skid_reg <= bus.in_data;
          end
          PS_FULL:  if (out_xfer) main_reg <= skid_reg;
          default:  main_reg <= main_reg;
        endcase
      end
    end
  end

  assign stall_inc = out_valid_reg & ~bus.out_ready & ~bus.flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (1'b0),
    .cnt   (bus.stall_cnt)
  );

  assign bus.out_valid = out_valid_reg;
  assign bus.in_ready  = in_ready_reg;
  assign bus.out_data  = main_reg;
  assign bus.occupancy = state_reg;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, async reset, saturation and a randomised queue scoreboard.
module tb_pipe_skid_stage;
  import pipe_pkg::*;

  localparam int          DW = 32;
  localparam int          CW = 4;
  localparam logic [31:0] RV = 32'h0000_00A5;
  localparam logic [31:0] FV = PIPE_BUBBLE_PC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_skid_stage_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  pipe_skid_stage #(
    .DATA_W(DW), .RESET_VAL(RV), .FLUSH_VAL(FV), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];
  logic [31:0] m_last;
  int          m_stall;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic [1:0]  e_occ;
    logic [31:0] e_data;
    logic [3:0]  e_st;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    m_last  = RV;
    m_stall = 0;
  endtask

  // One random cycle: check DUT against the queue model, then apply inputs and advance the model.
  task automatic rcycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    logic ixf, oxf;
    chk("rnd_occ",    32'(bus.occupancy), 32'(sb_q.size()));
    chk("rnd_occ_le2", 32'(bus.occupancy <= 2'd2), 32'd1);
    chk("rnd_in_ready", 32'(bus.in_ready), 32'(sb_q.size() < 2));
    chk("rnd_out_valid", 32'(bus.out_valid), 32'(sb_q.size() > 0));
    chk("rnd_out_data", bus.out_data, (sb_q.size() > 0) ? sb_q[0] : m_last);
    chk("rnd_stall", 32'(bus.stall_cnt), 32'(m_stall));
    drive(iv, d, ordy, fl);
    ixf = iv && (sb_q.size() < 2);
    oxf = (sb_q.size() > 0) && ordy;
    if ((sb_q.size() > 0) && !ordy && !fl && (m_stall < 15)) m_stall++;
    if (fl) begin
      sb_q.delete();
      m_last = FV;
    end else begin
      if (oxf) m_last = sb_q.pop_front();
      if (ixf) sb_q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    // iv, d, ordy, fl -> out_valid, in_ready, occupancy, out_data, stall_cnt after the edge
    vecs[0]  = '{1, 32'd1,  1, 0, 1, 1, 2'd1, 32'd1,  4'd0};
    vecs[1]  = '{1, 32'd2,  1, 0, 1, 1, 2'd1, 32'd2,  4'd0};
    vecs[2]  = '{1, 32'd3,  1, 0, 1, 1, 2'd1, 32'd3,  4'd0};
    vecs[3]  = '{1, 32'd4,  1, 0, 1, 1, 2'd1, 32'd4,  4'd0};
    vecs[4]  = '{0, 32'd0,  1, 0, 0, 1, 2'd0, 32'd4,  4'd0};
    vecs[5]  = '{1, 32'hA,  0, 0, 1, 1, 2'd1, 32'hA,  4'd0};
    vecs[6]  = '{1, 32'hB,  0, 0, 1, 0, 2'd2, 32'hA,  4'd1};
    vecs[7]  = '{1, 32'hC,  0, 0, 1, 0, 2'd2, 32'hA,  4'd2};
    vecs[8]  = '{1, 32'hC,  1, 0, 1, 1, 2'd1, 32'hB,  4'd2};
    vecs[9]  = '{1, 32'hC,  1, 0, 1, 1, 2'd1, 32'hC,  4'd2};
    vecs[10] = '{0, 32'd0,  1, 0, 0, 1, 2'd0, 32'hC,  4'd2};
    vecs[11] = '{1, 32'd11, 0, 0, 1, 1, 2'd1, 32'd11, 4'd2};
    vecs[12] = '{1, 32'd12, 0, 0, 1, 0, 2'd2, 32'd11, 4'd3};
    vecs[13] = '{1, 32'd13, 0, 1, 0, 1, 2'd0, FV,     4'd3};
    vecs[14] = '{0, 32'd0,  1, 0, 0, 1, 2'd0, FV,     4'd3};
    vecs[15] = '{1, 32'd15, 1, 0, 1, 1, 2'd1, 32'd15, 4'd3};
    vecs[16] = '{0, 32'd0,  1, 0, 0, 1, 2'd0, 32'd15, 4'd3};

    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_occ",       32'(bus.occupancy), 32'd0);
    chk("rst_out_data",  bus.out_data,       RV);
    chk("rst_stall",     32'(bus.stall_cnt), 32'd0);

    // T1: fill two entries and stall, then pull rst_n low between clock edges
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_occ_full", 32'(bus.occupancy), 32'd2);
    chk("t1_stall_pre", 32'(bus.stall_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_async_in_ready",  32'(bus.in_ready),  32'd1);
    chk("t1_async_occ",       32'(bus.occupancy), 32'd0);
    chk("t1_async_out_data",  bus.out_data,       RV);
    chk("t1_async_stall",     32'(bus.stall_cnt), 32'd0);
    $display("t1 async reset: out_valid=%0d occ=%0d data=%0h", bus.out_valid, bus.occupancy, bus.out_data);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // T2-T4 from the vector table
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_in_ready", i),  32'(bus.in_ready),  32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_occ", i),       32'(bus.occupancy), 32'(vecs[i].e_occ));
      chk($sformatf("vec%0d_out_data", i),  bus.out_data,       vecs[i].e_data);
      chk($sformatf("vec%0d_stall", i),     32'(bus.stall_cnt), 32'(vecs[i].e_st));
      $display("vec %0d: iv=%0d d=%0h ordy=%0d fl=%0d -> ov=%0d ir=%0d occ=%0d data=%0h stall=%0d",
               i, vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl,
               bus.out_valid, bus.in_ready, bus.occupancy, bus.out_data, bus.stall_cnt);
    end

    // T5: 4-bit stall counter saturates and survives a flush
    do_reset();
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    chk("t5_stall_14", 32'(bus.stall_cnt), 32'd14);
    repeat (6) @(negedge clk);
    chk("t5_stall_sat", 32'(bus.stall_cnt), 32'd15);
    repeat (3) @(negedge clk);
    chk("t5_stall_hold", 32'(bus.stall_cnt), 32'd15);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t5_flush_occ", 32'(bus.occupancy), 32'd0);
    chk("t5_flush_stall", 32'(bus.stall_cnt), 32'd15);
    @(negedge clk);
    chk("t5_post_flush_stall", 32'(bus.stall_cnt), 32'd15);
    $display("t5 saturation: stall_cnt=%0d", bus.stall_cnt);

    // T6: random traffic against the scoreboard queue
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      rcycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
             $urandom_range(0, 49) == 0);
    end
    rcycle(1'b0, 32'h0, 1'b1, 1'b0);
    $display("t6 random: done, queue depth %0d", sb_q.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
